// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button front end: hold FSM encodings and
// elaboration-time sizing helpers.
package button_debouncer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  // Bits needed to hold values 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single button: 2-flop synchroniser, stable-count debounce, hold/repeat timing.
// Latency pin->level 2+STABLE_CYCLES; no backpressure, strobes are one cycle wide.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000,
  parameter int HOLD_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic long_p,
  output logic repeat_p
);

  localparam int SC_W = clog2(STABLE_CYCLES + 1);
  localparam int HC_W = clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [SC_W-1:0] SC_LAST   = SC_W'(STABLE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] RPT_LAST  = HC_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit              RPT_EN    = (REPEAT_CYCLES > 0);

  logic            s1;
  logic            s2;
  logic [SC_W-1:0] sc;
  logic [HC_W-1:0] hc;
  logic [1:0]      state;
  logic            differ;
  logic            flip;
  logic            rise;
  logic            fall;

  assign differ = (s2 != level);
  assign flip   = differ && (sc == SC_LAST);
  assign rise   = flip && !level;
  assign fall   = flip && level;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      sc        <= '0;
      level     <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
      hc        <= '0;
      state     <= ST_IDLE;
    end else begin
      s1        <= din;
      s2        <= s1;
      press_p   <= rise;
      release_p <= fall;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;

      // Any sample matching the current level throws away accumulated credit.
      if (!differ) begin
        sc <= '0;
      end else if (flip) begin
        sc    <= '0;
        level <= ~level;
      end else begin
        sc <= sc + 1'b1;
      end

      // A debounced release overrides any long/repeat due on the same edge.
      if (fall) begin
        state <= ST_IDLE;
        hc    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state <= ST_PRESSED;
              hc    <= '0;
            end
          end
          ST_PRESSED: begin
            if (hc == HOLD_LAST) begin
              long_p <= 1'b1;
              hc     <= '0;
              state  <= ST_LONG;
            end else begin
              hc <= hc + 1'b1;
            end
          end
          ST_LONG: begin
            if (RPT_EN) begin
              if (hc == RPT_LAST) begin
                repeat_p <= 1'b1;
                hc       <= '0;
              end else begin
                hc <= hc + 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            hc    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// N-channel button front end: polarity normalisation then one debouncer per pin.
// Latency pin->press_p 2+STABLE_CYCLES; no backpressure, all channels independent.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_CH          = 5,
  parameter int STABLE_CYCLES = 1000000,
  parameter int HOLD_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] repeat_p
);

  localparam logic POL = (ACTIVE_LOW != 0);

  logic [N_CH-1:0] btn_pol;

  // Inverted ahead of the synchroniser so its reset value means "not pressed".
  assign btn_pol = btn_raw ^ {N_CH{POL}};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .din       (btn_pol[i]),
      .level     (btn_level[i]),
      .press_p   (press_p[i]),
      .release_p (release_p[i]),
      .long_p    (long_p[i]),
      .repeat_p  (repeat_p[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised + directed bench for button_debouncer with a queue-based scoreboard
// fed by a window/elapsed-time reference model.
module tb_button_debouncer;

  localparam int N  = 5;
  localparam int SC = 4;
  localparam int HC = 20;
  localparam int RC = 8;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] rpt;
  } obs_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, press_p, release_p, long_p, repeat_p;

  logic         rst_al;
  logic [N-1:0] raw_al;
  logic [N-1:0] al_lvl, al_prs, al_rel, al_lng, al_rpt;

  int checks   = 0;
  int failures = 0;

  button_debouncer #(
    .N_CH(N), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_p(press_p), .release_p(release_p), .long_p(long_p), .repeat_p(repeat_p)
  );

  button_debouncer #(
    .N_CH(N), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst(rst_al), .btn_raw(raw_al), .btn_level(al_lvl),
    .press_p(al_prs), .release_p(al_rel), .long_p(al_lng), .repeat_p(al_rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level flips once the last SC synchronised samples all
  // disagree with it; long/repeat follow from cycles elapsed since the press.
  bit           m_hist[N][$];
  logic [N-1:0] m_lvl;
  int           m_pcyc[N];
  int           ecount;

  obs_t exp_q[$];
  int   idx_q[$];

  int press_log[N][$];
  int rel_log[N][$];
  int long_log[N][$];
  int rpt_log[N][$];

  task automatic model_step(input logic r, input logic [N-1:0] p);
    obs_t o;
    int   n;
    int   d;
    bit   all_diff;
    o = '0;
    ecount++;
    for (int ch = 0; ch < N; ch++) begin
      if (r) begin
        m_hist[ch].delete();
        repeat (SC + 2) m_hist[ch].push_back(1'b0);
        m_lvl[ch] = 1'b0;
      end else begin
        n = m_hist[ch].size();
        all_diff = 1'b1;
        for (int k = 0; k < SC; k++)
          if (m_hist[ch][n-2-k] == m_lvl[ch]) all_diff = 1'b0;
        o.prs[ch] = all_diff && !m_lvl[ch];
        o.rel[ch] = all_diff && m_lvl[ch];
        o.lvl[ch] = all_diff ? !m_lvl[ch] : m_lvl[ch];
        if (m_lvl[ch] && !o.rel[ch]) begin
          d = ecount - m_pcyc[ch];
          o.lng[ch] = (d == HC);
          o.rpt[ch] = (d > HC) && (((d - HC) % RC) == 0);
        end
        if (o.prs[ch]) m_pcyc[ch] = ecount;
        m_lvl[ch] = o.lvl[ch];
        m_hist[ch].push_back(p[ch]);
        if (m_hist[ch].size() > SC + 4) void'(m_hist[ch].pop_front());
      end
    end
    exp_q.push_back(o);
    idx_q.push_back(ecount);
  endtask

  task automatic tick(input logic r, input logic [N-1:0] p);
    rst     = r;
    btn_raw = p;
    @(posedge clk);
    #1;
    model_step(r, p);
  endtask

  task automatic run(input int n, input logic [N-1:0] p);
    repeat (n) tick(1'b0, p);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int ch = 0; ch < N; ch++) begin
      press_log[ch].delete();
      rel_log[ch].delete();
      long_log[ch].delete();
      rpt_log[ch].delete();
    end
  endtask

  task automatic chk_log(input string name, input int act[$], input int expv[$]);
    bit bad;
    bad = (act.size() != expv.size());
    if (!bad)
      foreach (act[i]) if (act[i] != expv[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s: got cycles %p, expected cycles %p", name, act, expv);
    end
  endtask

  task automatic chk_vec(input string name, input logic [4*N-1:0] act, input logic [4*N-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output vector; pop and compare.
  always @(negedge clk) begin
    obs_t e;
    obs_t g;
    int   idx;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = idx_q.pop_front();
      g   = '{btn_level, press_p, release_p, long_p, repeat_p};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL cycle_%0d outputs: got lvl=%b prs=%b rel=%b lng=%b rpt=%b, expected lvl=%b prs=%b rel=%b lng=%b rpt=%b",
                 idx, g.lvl, g.prs, g.rel, g.lng, g.rpt, e.lvl, e.prs, e.rel, e.lng, e.rpt);
      end
      for (int ch = 0; ch < N; ch++) begin
        if (press_p[ch])   press_log[ch].push_back(idx);
        if (release_p[ch]) rel_log[ch].push_back(idx);
        if (long_p[ch])    long_log[ch].push_back(idx);
        if (repeat_p[ch])  rpt_log[ch].push_back(idx);
      end
    end
  end

  initial begin
    int           ev[$];
    int           ja, jb, jc, jd, je, jr, jl, pc, pd, p3;
    int           dur[N];
    logic [N-1:0] pins;
    logic         r;

    ecount = 0;
    m_lvl  = '0;
    for (int ch = 0; ch < N; ch++) begin
      m_pcyc[ch] = 0;
      dur[ch]    = 0;
      repeat (SC + 2) m_hist[ch].push_back(1'b0);
    end
    rst_al = 1'b1;
    raw_al = '0;

    repeat (3) tick(1'b1, '0);
    run(5, '0);
    settle();
    clear_logs();

    // Clean press on ch0: the first sample of the new level is taken at edge
    // ja, i.e. the pin moved one cycle earlier, so press_p lands 2+SC later.
    ja = ecount + 1;
    run(12, 5'b00001);
    run(15, '0);
    settle();
    ev.delete(); ev.push_back(ja + SC + 1);
    chk_log("ch0_press", press_log[0], ev);
    clear_logs();

    // Bouncing ch1: one press, counted from the final edge.
    tick(1'b0, 5'b00010);
    tick(1'b0, 5'b00000);
    tick(1'b0, 5'b00010);
    tick(1'b0, 5'b00000);
    jb = ecount + 1;
    run(12, 5'b00010);
    run(15, '0);
    settle();
    ev.delete(); ev.push_back(jb + SC + 1);
    chk_log("ch1_bounce_press", press_log[1], ev);
    clear_logs();

    // Long hold on ch2 with three auto-repeats, released before a fourth.
    jc = ecount + 1;
    pc = jc + SC + 1;
    run(50, 5'b00100);
    run(15, '0);
    settle();
    ev.delete(); ev.push_back(pc + HC);
    chk_log("ch2_long", long_log[2], ev);
    ev.delete(); ev.push_back(pc + HC + RC); ev.push_back(pc + HC + 2*RC); ev.push_back(pc + HC + 3*RC);
    chk_log("ch2_repeat", rpt_log[2], ev);
    ev.delete(); ev.push_back(pc + 50);
    chk_log("ch2_release", rel_log[2], ev);
    clear_logs();

    // ch4 debounced release lands exactly on the long_p cycle.
    jd = ecount + 1;
    pd = jd + SC + 1;
    run(20, 5'b10000);
    run(15, '0);
    settle();
    ev.delete();
    chk_log("ch4_long_suppressed", long_log[4], ev);
    chk_log("ch4_no_repeat", rpt_log[4], ev);
    ev.push_back(pd + HC);
    chk_log("ch4_release", rel_log[4], ev);
    clear_logs();

    // Reset mid-hold on ch3, pin kept pressed through it.
    je = ecount + 1;
    p3 = je + SC + 1;
    run(15, 5'b01000);
    tick(1'b1, 5'b01000);
    jr = ecount + 1;
    run(12, 5'b01000);
    jl = ecount + 1;
    run(15, '0);
    settle();
    ev.delete(); ev.push_back(p3); ev.push_back(jr + SC + 1);
    chk_log("ch3_press_around_rst", press_log[3], ev);
    ev.delete(); ev.push_back(jl + SC + 1);
    chk_log("ch3_release_only_final", rel_log[3], ev);
    clear_logs();

    // Random bounces, holds and occasional resets on all channels.
    pins = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (dur[ch] == 0) begin
          pins[ch] = 1'($urandom_range(0, 1));
          dur[ch]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 45));
        end
        dur[ch]--;
      end
      r = ($urandom_range(0, 249) == 0);
      tick(r, pins);
    end
    run(30, '0);
    settle();

    // Active-low instance: pins low (pressed) through reset.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_vec($sformatf("al_in_reset_%0d", k), {al_lvl, al_prs, al_rel, al_lng | al_rpt}, '0);
    end
    rst_al = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      chk_vec($sformatf("al_press_k%0d", k), {15'd0, al_prs}, {15'd0, (k == SC + 2) ? 5'b11111 : 5'b00000});
      chk_vec($sformatf("al_level_k%0d", k), {15'd0, al_lvl}, {15'd0, (k >= SC + 2) ? 5'b11111 : 5'b00000});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
